// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
//   Shared definitions for the audio transmit path.
//   - FMT_I2S / FMT_LJ : values of the frame-format select input.
//   - frame_t          : one stereo pair {left, right} at the default sample
//                        width, for code that moves whole pairs around.
//   - level_w()        : width of a FIFO occupancy count for a given depth
//                        (needs to represent 0..depth inclusive).
// ---------------------------------------------------------------------------
package audio_pkg;

  localparam logic FMT_I2S = 1'b0;
  localparam logic FMT_LJ  = 1'b1;

  localparam int DEF_SAMPLE_W = 16;

  typedef struct packed {
    logic [DEF_SAMPLE_W-1:0] left;
    logic [DEF_SAMPLE_W-1:0] right;
  } frame_t;

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// ---------------------------------------------------------------------------
// sample_fifo
//   Small synchronous FIFO with a first-word-fall-through head.
//   Ports:
//     clk, reset_n   : clock, synchronous active-low reset
//     wr_valid/ready : write handshake; wr_ready is low during reset and for
//                      the first cycle after it, then tracks "not full"
//     wr_data        : word to store
//     rd_en          : pop the head (ignored when empty)
//     rd_data        : current head word (valid while !empty)
//     empty          : no words stored
//     level          : number of words stored (0..DEPTH)
//   DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sample_fifo
  import audio_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      wr_valid,
  input  logic [WIDTH-1:0]          wr_data,
  output logic                      wr_ready,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      empty,
  output logic [level_w(DEPTH)-1:0] level
);

  localparam int LW = level_w(DEPTH);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_d;
  logic             init_q;
  logic             push;
  logic             pop;

  // init_q keeps ready low for the cycle in which reset is released.
  assign wr_ready = init_q && (level_q < LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_en && !empty;
  assign rd_data  = mem_q[rd_ptr_q];
  assign level    = level_q;

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      init_q   <= 1'b0;
    end else begin
      init_q  <= 1'b1;
      level_q <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/i2s_tx_stereo.sv
// ---------------------------------------------------------------------------
// i2s_tx_stereo
//   Stereo I2S / left-justified transmitter for the WM8731 DAC path.
//   Ports:
//     clk, reset_n      : MCLK-rate clock, synchronous active-low reset
//     en                : run the serialiser (0 idles pins, FIFO retained)
//     fmt               : 0 = I2S (MSB one BCLK late), 1 = left-justified
//     mono              : send the left sample in both slots
//     s_valid/s_ready   : sample-pair input handshake
//     s_left, s_right   : two's-complement samples
//     fifo_level        : pairs buffered
//     underrun          : 1-clk pulse when a frame starts with no data
//     AUD_BCLK          : bit clock, MCLK_DIV clk cycles per period
//     AUD_DACLRCK       : 0 = left slot, 1 = right slot
//     AUD_DACDAT        : serial data, changes on BCLK falling edges
//   Constraints: 8 <= SAMPLE_W <= SLOT_W, MCLK_DIV even and >= 2,
//   FIFO_DEPTH a power of two >= 2.
// ---------------------------------------------------------------------------
module i2s_tx_stereo
  import audio_pkg::*;
#(
  parameter int SAMPLE_W   = 16,
  parameter int SLOT_W     = 32,
  parameter int MCLK_DIV   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           en,
  input  logic                           fmt,
  input  logic                           mono,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [SAMPLE_W-1:0]            s_left,
  input  logic [SAMPLE_W-1:0]            s_right,
  output logic [level_w(FIFO_DEPTH)-1:0] fifo_level,
  output logic                           underrun,
  output logic                           AUD_BCLK,
  output logic                           AUD_DACLRCK,
  output logic                           AUD_DACDAT
);

  localparam int MW = $clog2(MCLK_DIV);
  localparam int BW = $clog2(2 * SLOT_W);
  localparam int IW = $clog2(SAMPLE_W);

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } pair_t;

  logic [MW-1:0] mcnt_q, mcnt_d;
  logic [BW-1:0] bpos_q, bpos_d;
  logic          active_q, active_d;   // a frame is in progress
  logic          fmt_q, fmt_d;
  pair_t         frame_q, frame_d;
  logic          bclk_q, bclk_d;
  logic          lrck_q, lrck_d;
  logic          dat_q, dat_d;
  logic          underrun_q, underrun_d;

  pair_t         head;
  logic          fifo_empty;
  logic          pop;
  logic          fall;
  logic          boundary;
  logic          slot_nxt;
  logic [BW-1:0] p_nxt;
  logic [SAMPLE_W-1:0] smp;
  logic          carry;
  logic          bit_nxt;

  sample_fifo #(
    .WIDTH (2 * SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_valid (s_valid),
    .wr_data  ({s_left, s_right}),
    .wr_ready (s_ready),
    .rd_en    (pop),
    .rd_data  (head),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  // Fall event: mcnt wraps, BCLK drops, data and LRCK may change.
  assign fall = en && (mcnt_q == MW'(MCLK_DIV - 1));

  always_comb begin
    mcnt_d     = '0;
    bpos_d     = bpos_q;
    active_d   = active_q;
    fmt_d      = fmt_q;
    frame_d    = frame_q;
    boundary   = 1'b0;
    pop        = 1'b0;

    if (en) begin
      mcnt_d = fall ? '0 : mcnt_q + 1'b1;
      if (fall) begin
        // The first fall event after enabling always opens a frame.
        if (!active_q || (bpos_q == BW'(2 * SLOT_W - 1))) begin
          boundary = 1'b1;
          bpos_d   = '0;
        end else begin
          bpos_d = bpos_q + 1'b1;
        end
        active_d = 1'b1;
      end
    end else begin
      bpos_d   = '0;
      active_d = 1'b0;
      frame_d  = '0;
    end

    if (boundary) begin
      fmt_d = fmt;
      if (!fifo_empty) begin
        pop           = 1'b1;
        frame_d.left  = head.left;
        frame_d.right = mono ? head.left : head.right;
      end else begin
        frame_d = '0;
      end
    end

    // Slot and in-slot position of the bit about to be driven.
    slot_nxt = (bpos_d >= BW'(SLOT_W));
    p_nxt    = slot_nxt ? (bpos_d - BW'(SLOT_W)) : bpos_d;
    smp      = slot_nxt ? frame_d.right : frame_d.left;
    // In I2S with full-width slots the LSB spills into the next slot's p=0.
    carry    = slot_nxt ? frame_d.left[0] : frame_q.right[0];

    bit_nxt = 1'b0;
    if (fmt_d == FMT_LJ) begin
      if (int'(p_nxt) < SAMPLE_W) bit_nxt = smp[IW'(SAMPLE_W - 1 - int'(p_nxt))];
    end else if (p_nxt == '0) begin
      bit_nxt = (SLOT_W == SAMPLE_W) ? carry : 1'b0;
    end else if (int'(p_nxt) <= SAMPLE_W) begin
      bit_nxt = smp[IW'(SAMPLE_W - int'(p_nxt))];
    end

    bclk_d     = en && (mcnt_d >= MW'(MCLK_DIV / 2));
    lrck_d     = 1'b0;
    dat_d      = 1'b0;
    if (en) begin
      lrck_d = fall ? slot_nxt : lrck_q;
      dat_d  = fall ? bit_nxt  : dat_q;
    end
    underrun_d = boundary && fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mcnt_q     <= '0;
      bpos_q     <= '0;
      active_q   <= 1'b0;
      fmt_q      <= 1'b0;
      frame_q    <= '0;
      bclk_q     <= 1'b0;
      lrck_q     <= 1'b0;
      dat_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      mcnt_q     <= mcnt_d;
      bpos_q     <= bpos_d;
      active_q   <= active_d;
      fmt_q      <= fmt_d;
      frame_q    <= frame_d;
      bclk_q     <= bclk_d;
      lrck_q     <= lrck_d;
      dat_q      <= dat_d;
      underrun_q <= underrun_d;
    end
  end

  assign AUD_BCLK    = bclk_q;
  assign AUD_DACLRCK = lrck_q;
  assign AUD_DACDAT  = dat_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_tx_stereo.sv
// ---------------------------------------------------------------------------
// tb_i2s_tx_stereo
//   Bench for i2s_tx_stereo at the default parameters (16-bit samples,
//   32-bit slots, MCLK/8, 4-deep FIFO: one frame = 64 BCLK = 512 clk).
//   Serial output is captured on every BCLK rise and assembled into 64-bit
//   frame words (first bit = MSB) which are compared against whole-frame
//   expectations.
// ---------------------------------------------------------------------------
module tb_i2s_tx_stereo;
  import audio_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        fmt = 1'b0;
  logic        mono = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_left = '0;
  logic [15:0] s_right = '0;
  logic [2:0]  fifo_level;
  logic        underrun;
  logic        AUD_BCLK;
  logic        AUD_DACLRCK;
  logic        AUD_DACDAT;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] cap_d[$];
  logic [63:0] cap_lr[$];
  int          ur_cnt;
  bit          timed_out;

  localparam logic [63:0] LR_PAT = 64'h00000000_FFFFFFFF;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        f;
    logic        m;
    logic [63:0] exp;
  } vec_t;

  vec_t   vecs[5];
  frame_t q[$];

  always #5 clk = ~clk;

  i2s_tx_stereo #(
    .SAMPLE_W   (16),
    .SLOT_W     (32),
    .MCLK_DIV   (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .fmt         (fmt),
    .mono        (mono),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_left      (s_left),
    .s_right     (s_right),
    .fifo_level  (fifo_level),
    .underrun    (underrun),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_DACLRCK (AUD_DACLRCK),
    .AUD_DACDAT  (AUD_DACDAT)
  );

  // One slot as seen on the wire: LJ puts the MSB at p=0, I2S one bit later.
  function automatic logic [31:0] slot_word(input logic [15:0] s, input logic f);
    return f ? {s, 16'h0000} : {1'b0, s, 15'h0000};
  endfunction

  function automatic logic [63:0] exp_frame(input frame_t fr, input logic f, input logic m);
    return {slot_word(fr.left, f), slot_word(m ? fr.left : fr.right, f)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset_n = 1'b0; en = 1'b0; s_valid = 1'b0; fmt = 1'b0; mono = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(1);
  endtask

  // Called at a negedge; the pair is taken at the following posedge.
  task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
    s_valid = 1'b1; s_left = l; s_right = r;
    tick(1);
    s_valid = 1'b0;
  endtask

  // Enable the serialiser from idle and capture nf frames. The BCLK pulse
  // that precedes the first fall event carries no frame data and is skipped.
  // Optional: push one pair at clock push_at, toggle fmt at clock tog_at.
  task automatic run_frames(input int nf, input int push_at, input logic [15:0] pl,
                            input logic [15:0] pr, input int tog_at);
    int   rises;
    int   clk_i;
    logic prev;
    cap_d.delete(); cap_lr.delete();
    ur_cnt = 0; timed_out = 1'b0;
    rises = 0; clk_i = 0; prev = 1'b0;
    en = 1'b1;
    while (rises < 1 + nf * 64) begin
      @(negedge clk);
      clk_i++;
      if (underrun) ur_cnt++;
      if (AUD_BCLK && !prev) begin
        if (rises >= 1) begin
          if ((rises - 1) % 64 == 0) begin
            cap_d.push_back('0);
            cap_lr.push_back('0);
          end
          cap_d[cap_d.size()-1]   = {cap_d[cap_d.size()-1][62:0], AUD_DACDAT};
          cap_lr[cap_lr.size()-1] = {cap_lr[cap_lr.size()-1][62:0], AUD_DACLRCK};
        end
        rises++;
      end
      prev = AUD_BCLK;
      if (clk_i == push_at) begin
        s_valid = 1'b1; s_left = pl; s_right = pr;
      end else begin
        s_valid = 1'b0;
      end
      if (clk_i == tog_at) fmt = ~fmt;
      if (clk_i > nf * 600 + 50) begin
        timed_out = 1'b1;
        break;
      end
    end
    s_valid = 1'b0;
    check("capture_timeout", 64'(timed_out), 64'(0));
  endtask

  task automatic check_frame(input int k, input logic [63:0] exp);
    if (k >= cap_d.size()) begin
      n_cmp++; n_err++;
      $display("FAIL frame_missing: frame %0d got none want %h", k, exp);
    end else begin
      $display("frame %0d: dat=%h lr=%h exp=%h", k, cap_d[k], cap_lr[k], exp);
      check("frame_data", cap_d[k], exp);
      check("frame_lrck", cap_lr[k], LR_PAT);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int     acc;
    int     n;
    int     nf;
    logic   f;
    logic   m;
    frame_t p;

    vecs[0] = '{16'hA5C3, 16'h0F01, 1'b0, 1'b0, 64'h52E18000_07808000};
    vecs[1] = '{16'h8001, 16'h7FFF, 1'b1, 1'b1, 64'h80010000_80010000};
    vecs[2] = '{16'h8001, 16'h7FFF, 1'b1, 1'b0, 64'h80010000_7FFF0000};
    vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 64'h7FFF8000_00008000};
    vecs[4] = '{16'h1234, 16'hABCD, 1'b0, 1'b1, 64'h091A0000_091A0000};

    // ---- reset while active, with s_valid held high ----
    tick(2);
    reset_n = 1'b1;
    tick(1);
    push_pair(16'h1111, 16'h2222);
    push_pair(16'h3333, 16'h4444);
    en = 1'b1;
    tick(100);
    check("pre_reset_level", 64'(fifo_level), 64'(1));
    reset_n = 1'b0; s_valid = 1'b1; s_left = 16'hDEAD; s_right = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("reset_outputs",
            64'({s_ready, underrun, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, fifo_level}), 64'(0));
    end
    reset_n = 1'b1; en = 1'b0;
    tick(1);
    check("ready_after_release", 64'(s_ready), 64'(1));
    check("level_after_release", 64'(fifo_level), 64'(0));
    s_valid = 1'b0;
    $display("reset sequence done");

    // ---- table-driven single frames ----
    for (int v = 0; v < 5; v++) begin
      do_reset;
      fmt = vecs[v].f; mono = vecs[v].m;
      push_pair(vecs[v].l, vecs[v].r);
      run_frames(1, -1, 16'h0, 16'h0, -1);
      $display("vector %0d: L=%h R=%h fmt=%0d mono=%0d", v, vecs[v].l, vecs[v].r, vecs[v].f, vecs[v].m);
      check_frame(0, vecs[v].exp);
      check("vec_underrun", 64'(ur_cnt), 64'(0));
    end

    // ---- backpressure with en=0, then one pop per frame ----
    do_reset;
    acc = 0;
    s_valid = 1'b1; s_left = 16'h1000; s_right = 16'h2000;
    for (int i = 0; i < 8; i++) begin
      if (s_ready) acc++;
      tick(1);
      s_left = s_left + 16'h1;
    end
    s_valid = 1'b0;
    $display("backpressure: accepted=%0d level=%0d ready=%0d", acc, fifo_level, s_ready);
    check("bp_accepted", 64'(acc), 64'(4));
    check("bp_ready_full", 64'(s_ready), 64'(0));
    check("bp_level_full", 64'(fifo_level), 64'(4));
    en = 1'b1;
    tick(7);
    check("bp_level_before_boundary", 64'(fifo_level), 64'(4));
    tick(1);
    check("bp_level_first_pop", 64'(fifo_level), 64'(3));
    check("bp_ready_after_pop", 64'(s_ready), 64'(1));
    tick(512);
    check("bp_level_second_pop", 64'(fifo_level), 64'(2));

    // ---- underrun, then a push mid-frame ----
    do_reset;
    run_frames(3, 700, 16'hC0DE, 16'h1234, -1);
    $display("underrun: pulses=%0d", ur_cnt);
    check("ur_count", 64'(ur_cnt), 64'(2));
    check_frame(0, 64'h0);
    check_frame(1, 64'h0);
    p.left = 16'hC0DE; p.right = 16'h1234;
    check_frame(2, exp_frame(p, 1'b0, 1'b0));

    // ---- fmt toggled at bpos 20 only affects the next frame ----
    do_reset;
    push_pair(16'h9ABC, 16'h3C3C);
    push_pair(16'h5555, 16'hF00F);
    run_frames(2, -1, 16'h0, 16'h0, 8 + 20 * 8 + 2);
    $display("fmt toggle: frames=%0d", cap_d.size());
    p.left = 16'h9ABC; p.right = 16'h3C3C;
    check_frame(0, exp_frame(p, 1'b0, 1'b0));
    p.left = 16'h5555; p.right = 16'hF00F;
    check_frame(1, exp_frame(p, 1'b1, 1'b0));

    // ---- en dropped at bpos 40, then a fresh frame ----
    do_reset;
    push_pair(16'h1357, 16'h2468);
    push_pair(16'hFEDC, 16'h0BA9);
    en = 1'b1;
    tick(8 + 40 * 8 + 3);
    check("drop_lrck_right_slot", 64'(AUD_DACLRCK), 64'(1));
    check("drop_level_before", 64'(fifo_level), 64'(1));
    en = 1'b0;
    tick(1);
    check("drop_pins_zero", 64'({AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, underrun}), 64'(0));
    check("drop_level_after", 64'(fifo_level), 64'(1));
    run_frames(1, -1, 16'h0, 16'h0, -1);
    $display("re-enable: frames=%0d level=%0d", cap_d.size(), fifo_level);
    p.left = 16'hFEDC; p.right = 16'h0BA9;
    check_frame(0, exp_frame(p, 1'b0, 1'b0));
    check("reenable_underrun", 64'(ur_cnt), 64'(0));

    // ---- randomized runs against the frame-queue model ----
    for (int it = 0; it < 6; it++) begin
      do_reset;
      q.delete();
      f  = 1'($urandom_range(0, 1));
      m  = 1'($urandom_range(0, 1));
      n  = int'($urandom_range(0, 4));
      nf = n + int'($urandom_range(1, 2));
      fmt = f; mono = m;
      for (int i = 0; i < n; i++) begin
        p.left  = 16'($urandom);
        p.right = 16'($urandom);
        q.push_back(p);
        push_pair(p.left, p.right);
      end
      check("rnd_level", 64'(fifo_level), 64'(n));
      run_frames(nf, -1, 16'h0, 16'h0, -1);
      $display("random %0d: fmt=%0d mono=%0d pairs=%0d frames=%0d underruns=%0d",
               it, f, m, n, nf, ur_cnt);
      for (int k = 0; k < nf; k++) begin
        check_frame(k, (k < n) ? exp_frame(q[k], f, m) : 64'h0);
      end
      check("rnd_underrun", 64'(ur_cnt), 64'(nf - n));
      check("rnd_level_end", 64'(fifo_level), 64'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
